// File: rtl/button_event_ctrl.sv
// Two-button debounce / auto-repeat controller. Each button has its own FSM and a one-deep
// pending slot; a round-robin arbiter feeds one valid/ready event register.
module button_event_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_RATE     = 8,
   parameter int CNT_W           = 5
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       btn_a,
   input  logic       btn_b,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic       evt_id,
   output logic       evt_repeat,
   output logic [1:0] held,
   output logic       evt_dropped
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, REPEAT} btn_state_e;

   localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] RD_MAX  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RR_MAX  = CNT_W'(REPEAT_RATE);

   logic [1:0] btn;
   logic [1:0] slot_v;
   logic [1:0] slot_r;
   logic [1:0] drop;
   logic       can_load;
   logic       load;
   logic       grant;
   logic       last_b;

   assign btn = {btn_b, btn_a};

   // The register may take a new event when empty or when the current one is accepted.
   assign can_load = !evt_valid || evt_ready;
   assign load     = can_load && (|slot_v);
   assign grant    = (&slot_v) ? ~last_b : slot_v[1];

   for (genvar i = 0; i < 2; i++) begin : g_btn
      btn_state_e       state;
      logic [CNT_W-1:0] dcnt;
      logic [CNT_W-1:0] rcnt;
      logic [CNT_W-1:0] dcnt_inc;
      logic [CNT_W-1:0] rcnt_inc;
      logic [CNT_W-1:0] rep_max;
      logic             req;
      logic             req_rep;
      logic             load_i;
      logic             sv;
      logic             sr;

      assign dcnt_inc = dcnt + 1'b1;
      assign rcnt_inc = rcnt + 1'b1;
      assign rep_max  = (state == PRESSED) ? RD_MAX : RR_MAX;
      assign held[i]  = (state == PRESSED) || (state == REPEAT);
      assign load_i   = load && (grant == 1'(i));

      // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
      always_comb begin
         req     = 1'b0;
         req_rep = 1'b0;
         if (btn[i]) begin
            if ((state == IDLE) || (state == DEBOUNCE)) begin
               req = (dcnt_inc == DEB_MAX);
            end else begin
               req     = (rcnt_inc == rep_max);
               req_rep = 1'b1;
            end
         end
      end

      // IDLE keeps dcnt at zero, so it shares the debounce count-up with DEBOUNCE.
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            state <= IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
         end else begin
            unique case (state)
               IDLE, DEBOUNCE: begin
                  if (!btn[i]) begin
                     state <= IDLE;
                     dcnt  <= '0;
                  end else if (dcnt_inc == DEB_MAX) begin
                     state <= PRESSED;
                     dcnt  <= '0;
                     rcnt  <= '0;
                  end else begin
                     state <= DEBOUNCE;
                     dcnt  <= dcnt_inc;
                  end
               end
               PRESSED, REPEAT: begin
                  if (btn[i]) begin
                     dcnt <= '0;
                     if (rcnt_inc == rep_max) begin
                        state <= REPEAT;
                        rcnt  <= '0;
                     end else begin
                        rcnt <= rcnt_inc;
                     end
                  end else if (dcnt_inc == DEB_MAX) begin
                     state <= IDLE;
                     dcnt  <= '0;
                     rcnt  <= '0;
                  end else begin
                     dcnt <= dcnt_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      // A request into a slot that stays occupied this cycle is lost; the old event is kept.
      assign drop[i] = req && sv && !load_i;

      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            sv <= 1'b0;
            sr <= 1'b0;
         end else if (req && !drop[i]) begin
            sv <= 1'b1;
            sr <= req_rep;
         end else if (load_i) begin
            sv <= 1'b0;
         end
      end

      assign slot_v[i] = sv;
      assign slot_r[i] = sr;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         evt_valid   <= 1'b0;
         evt_id      <= 1'b0;
         evt_repeat  <= 1'b0;
         evt_dropped <= 1'b0;
         last_b      <= 1'b1;
      end else begin
         if (load) begin
            evt_valid  <= 1'b1;
            evt_id     <= grant;
            evt_repeat <= slot_r[grant];
            last_b     <= grant;
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
         if (|drop) begin
            evt_dropped <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: directed scenarios plus random button/ready
// activity, compared every cycle against a run-length based reference model.
module tb_button_event_ctrl;

   localparam int DEB = 4;
   localparam int RD  = 16;
   localparam int RR  = 8;

   logic       clk = 1'b0;
   logic       nrst;
   logic       btn_a;
   logic       btn_b;
   logic       evt_ready;
   logic       evt_valid;
   logic       evt_id;
   logic       evt_repeat;
   logic       evt_dropped;
   logic [1:0] held;
   logic [5:0] obs;

   int compared   = 0;
   int mismatched = 0;

   button_event_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY   (RD),
      .REPEAT_RATE    (RR),
      .CNT_W          (5)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .btn_a      (btn_a),
      .btn_b      (btn_b),
      .evt_ready  (evt_ready),
      .evt_valid  (evt_valid),
      .evt_id     (evt_id),
      .evt_repeat (evt_repeat),
      .held       (held),
      .evt_dropped(evt_dropped)
   );

   always #5 clk = ~clk;

   assign obs = {evt_valid, evt_id, evt_repeat, held, evt_dropped};

   // Reference model: run lengths of high/low samples and total high samples since press.
   int m_hi_run [2];
   int m_lo_run [2];
   int m_hi_cnt [2];
   bit m_held   [2];
   bit m_slot_v [2];
   bit m_slot_r [2];
   bit m_ev_v, m_ev_id, m_ev_r, m_drop, m_last;

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_hi_run[i] = 0;
         m_lo_run[i] = 0;
         m_hi_cnt[i] = 0;
         m_held[i]   = 1'b0;
         m_slot_v[i] = 1'b0;
         m_slot_r[i] = 1'b0;
      end
      m_ev_v  = 1'b0;
      m_ev_id = 1'b0;
      m_ev_r  = 1'b0;
      m_drop  = 1'b0;
      m_last  = 1'b1;
   endfunction

   function automatic void model_step(input bit a, input bit b, input bit r);
      bit s   [2];
      bit req [2];
      bit rep [2];
      bit load;
      bit g;
      s[0] = a;
      s[1] = b;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0;
         rep[i] = 1'b0;
         if (!m_held[i]) begin
            if (s[i]) begin
               m_hi_run[i]++;
               if (m_hi_run[i] == DEB) begin
                  m_held[i]   = 1'b1;
                  m_hi_run[i] = 0;
                  m_hi_cnt[i] = 0;
                  req[i]      = 1'b1;
               end
            end else begin
               m_hi_run[i] = 0;
            end
         end else if (s[i]) begin
            m_lo_run[i] = 0;
            m_hi_cnt[i]++;
            if (m_hi_cnt[i] >= RD && ((m_hi_cnt[i] - RD) % RR) == 0) begin
               req[i] = 1'b1;
               rep[i] = 1'b1;
            end
         end else begin
            m_lo_run[i]++;
            if (m_lo_run[i] == DEB) begin
               m_held[i]   = 1'b0;
               m_lo_run[i] = 0;
               m_hi_cnt[i] = 0;
            end
         end
      end
      load = (!m_ev_v || r) && (m_slot_v[0] || m_slot_v[1]);
      g    = (m_slot_v[0] && m_slot_v[1]) ? !m_last : m_slot_v[1];
      if (load) begin
         m_ev_v      = 1'b1;
         m_ev_id     = g;
         m_ev_r      = m_slot_r[g];
         m_last      = g;
         m_slot_v[g] = 1'b0;
      end else if (r) begin
         m_ev_v = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         if (req[i]) begin
            if (m_slot_v[i]) begin
               m_drop = 1'b1;
            end else begin
               m_slot_v[i] = 1'b1;
               m_slot_r[i] = rep[i];
            end
         end
      end
   endfunction

   function automatic logic [5:0] exp_vec();
      return {m_ev_v, m_ev_id, m_ev_r, m_held[1], m_held[0], m_drop};
   endfunction

   // Entered and left at a falling edge; inputs are applied before the next rising edge.
   task automatic cycle(input logic a, input logic b, input logic r);
      btn_a     = a;
      btn_b     = b;
      evt_ready = r;
      model_step(a, b, r);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      nrst      = 1'b0;
      btn_a     = 1'b0;
      btn_b     = 1'b0;
      evt_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_reset();
      nrst      = 1'b0;
      btn_a     = 1'b1;
      btn_b     = 1'b1;
      evt_ready = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      compared++;
      if (obs !== 6'b0) begin
         mismatched++;
         $display("FAIL reset_state: got %b want %b", obs, 6'b0);
      end
      do_reset();
      cycle(1'b0, 1'b0, 1'b0);
      compared++;
      if (obs !== exp_vec()) begin
         mismatched++;
         $display("FAIL reset_idle: got %b want %b", obs, exp_vec());
      end
   endtask

   task automatic test_clean_press();
      int events    = 0;
      int held_rise = 0;
      int held_fall = 0;
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         cycle(k <= 10, 1'b0, 1'b1);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL clean_press cyc %0d: got %b want %b", k, obs, exp_vec());
         end
         if (evt_valid) events++;
         if (held[0] && held_rise == 0) held_rise = k;
         if (!held[0] && held_rise != 0 && held_fall == 0) held_fall = k;
      end
      compared++;
      if (events != 1 || held_rise != DEB || held_fall != 10 + DEB) begin
         mismatched++;
         $display("FAIL clean_press_timing: got events=%0d rise=%0d fall=%0d want 1 %0d %0d",
                  events, held_rise, held_fall, DEB, 10 + DEB);
      end
   endtask

   task automatic test_bounce();
      logic [7:0] pat = 8'b0111_0111;
      int events = 0;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         cycle((k < 8) ? pat[k] : 1'b0, 1'b0, 1'b1);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL bounce cyc %0d: got %b want %b", k, obs, exp_vec());
         end
         if (evt_valid || held != 2'b00) events++;
      end
      compared++;
      if (events != 0) begin
         mismatched++;
         $display("FAIL bounce_no_event: got %0d active cycles want 0", events);
      end
   endtask

   task automatic test_repeat();
      int seen[$];
      int want[$];
      int t;
      do_reset();
      want.push_back(DEB + 1);
      t = DEB + RD;
      while (t + 1 <= 40) begin
         want.push_back(t + 1);
         t += RR;
      end
      for (int k = 1; k <= 46; k++) begin
         cycle(1'b0, k <= 40, 1'b1);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL repeat cyc %0d: got %b want %b", k, obs, exp_vec());
         end
         if (evt_valid && evt_id) seen.push_back(evt_repeat ? k : -k);
      end
      // Negative entries mark a non-repeat event; only the first one may be a press.
      compared++;
      if (seen.size() != want.size()) begin
         mismatched++;
         $display("FAIL repeat_count: got %0d want %0d", seen.size(), want.size());
      end else begin
         for (int j = 0; j < want.size(); j++) begin
            if (seen[j] != ((j == 0) ? -want[j] : want[j])) begin
               mismatched++;
               $display("FAIL repeat_edge %0d: got %0d want %0d", j, seen[j], want[j]);
            end
         end
      end
   endtask

   task automatic run_pair(input logic a_on, input logic b_on, output int ids[$]);
      ids = {};
      for (int k = 1; k <= 12; k++) begin
         cycle(a_on && k <= 6, b_on && k <= 6, 1'b1);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL tie cyc %0d: got %b want %b", k, obs, exp_vec());
         end
         if (evt_valid) ids.push_back(int'(evt_id));
      end
   endtask

   task automatic test_back_to_back();
      int ids[$];
      do_reset();
      run_pair(1'b1, 1'b1, ids);
      compared++;
      if (ids.size() != 2 || ids[0] != 0 || ids[1] != 1) begin
         mismatched++;
         $display("FAIL tie_first: got %p want '{0,1}", ids);
      end
      // A solo press of A leaves A as last grant, so the following tie goes to B.
      run_pair(1'b1, 1'b0, ids);
      run_pair(1'b1, 1'b1, ids);
      compared++;
      if (ids.size() != 2 || ids[0] != 1 || ids[1] != 0) begin
         mismatched++;
         $display("FAIL tie_second: got %p want '{1,0}", ids);
      end
   endtask

   task automatic test_backpressure();
      int accepted = 0;
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         cycle(1'b1, 1'b0, 1'b0);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL stall cyc %0d: got %b want %b", k, obs, exp_vec());
         end
      end
      compared++;
      if ({evt_valid, evt_id, evt_repeat, evt_dropped} !== 4'b1001) begin
         mismatched++;
         $display("FAIL stall_hold: got %b want 1001", {evt_valid, evt_id, evt_repeat, evt_dropped});
      end
      for (int k = 1; k <= 8; k++) begin
         if (evt_valid) accepted++;
         cycle(1'b0, 1'b0, 1'b1);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL drain cyc %0d: got %b want %b", k, obs, exp_vec());
         end
      end
      compared++;
      if (accepted != 2 || evt_dropped !== 1'b1) begin
         mismatched++;
         $display("FAIL drain_count: got %0d dropped=%b want 2 dropped=1", accepted, evt_dropped);
      end
   endtask

   task automatic test_reset_mid();
      int first_evt = 0;
      do_reset();
      for (int k = 1; k <= 21; k++) begin
         cycle(1'b1, 1'b0, 1'b0);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL pre_reset cyc %0d: got %b want %b", k, obs, exp_vec());
         end
      end
      #2 nrst = 1'b0;
      #1;
      compared++;
      if (obs !== 6'b0) begin
         mismatched++;
         $display("FAIL async_reset: got %b want %b", obs, 6'b0);
      end
      model_reset();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      for (int k = 1; k <= DEB + 3; k++) begin
         cycle(1'b1, 1'b0, 1'b1);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL post_reset cyc %0d: got %b want %b", k, obs, exp_vec());
         end
         if (evt_valid && first_evt == 0) first_evt = k;
      end
      compared++;
      if (first_evt != DEB + 1) begin
         mismatched++;
         $display("FAIL post_reset_latency: got %0d want %0d", first_evt, DEB + 1);
      end
   endtask

   task automatic test_random();
      logic a = 1'b0;
      logic b = 1'b0;
      logic r;
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(13) == 0) a = ~a;
         if ($urandom_range(13) == 0) b = ~b;
         // Second half starves the consumer so pending slots fill and drop.
         r = (k < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(7) == 0);
         cycle(a, b, r);
         compared++;
         if (obs !== exp_vec()) begin
            mismatched++;
            $display("FAIL random cyc %0d: got %b want %b", k, obs, exp_vec());
         end
      end
   endtask

   initial begin
      nrst      = 1'b0;
      btn_a     = 1'b0;
      btn_b     = 1'b0;
      evt_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_repeat();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
